// File: rtl/issue_wakeup_arb_pkg.sv
// Shared issue-stage widths for the wake-up arbiter and the wake-up history table.
package issue_wakeup_arb_pkg;
    localparam int ROB_W    = 4;
    localparam int VAL_W    = 32;
    localparam int NREQ_DEF = 4;

    typedef struct packed {
        logic [ROB_W-1:0] rob;
        logic [VAL_W-1:0] value;
    } wk_entry_t;
endpackage

// File: rtl/issue_wakeup_pick2.sv
// Combinational two-of-N picker: first two set mask bits scanning upward from start_i, wrapping.
module issue_wakeup_pick2 #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] mask_i,
    input  logic [IW-1:0]   start_i,
    output logic [NREQ-1:0] gnt_a_o,
    output logic            vld_a_o,
    output logic [NREQ-1:0] gnt_b_o,
    output logic            vld_b_o
);
    logic [IW-1:0] idx;

    always_comb begin
        gnt_a_o = '0;
        gnt_b_o = '0;
        vld_a_o = 1'b0;
        vld_b_o = 1'b0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            // NREQ is a power of two, so the IW-bit add wraps modulo NREQ
            idx = start_i + IW'(k);
            if (mask_i[idx]) begin
                if (!vld_a_o) begin
                    gnt_a_o[idx] = 1'b1;
                    vld_a_o      = 1'b1;
                end else if (!vld_b_o) begin
                    gnt_b_o[idx] = 1'b1;
                    vld_b_o      = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/issue_wakeup_arb.sv
// Wake-up arbiter: one skid entry per requester, up to two registered wake-ups per cycle.
// Define ISSUE_WAKEUP_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module issue_wakeup_arb
    import issue_wakeup_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*ROB_W-1:0] req_rob,
    input  logic [NREQ*VAL_W-1:0] req_value,
    output logic [NREQ-1:0]       req_ready,
    output logic                  wea,
    output logic [ROB_W-1:0]      dina_rob,
    output logic [VAL_W-1:0]      dina_value,
    output logic                  web,
    output logic [ROB_W-1:0]      dinb_rob,
    output logic [VAL_W-1:0]      dinb_value
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0] ent_vld;
    wk_entry_t       ent [NREQ];
    logic [NREQ-1:0] pk_a, pk_b, grant, xfer;
    logic            pk_a_vld, pk_b_vld;
    logic [IW-1:0]   start;

    function automatic logic [IW-1:0] oh2idx(input logic [NREQ-1:0] oh);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) r = IW'(i);
        end
        return r;
    endfunction

    issue_wakeup_pick2 #(.NREQ(NREQ), .IW(IW)) u_pick2 (
        .mask_i  (ent_vld),
        .start_i (start),
        .gnt_a_o (pk_a),
        .vld_a_o (pk_a_vld),
        .gnt_b_o (pk_b),
        .vld_b_o (pk_b_vld)
    );

    // Flush suppresses all grants and blocks new transfers for that cycle
    assign grant     = flush ? '0 : (pk_a | pk_b);
    assign req_ready = flush ? '0 : (~ent_vld | grant);
    assign xfer      = req_valid & req_ready;

`ifdef ISSUE_WAKEUP_ARB_FIXED_PRIO_EN
    assign start = '0;
`else
    logic [IW-1:0] ptr_q, ptr_d;

    assign start = ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (!flush && pk_b_vld) begin
            ptr_d = oh2idx(pk_b) + IW'(1);
        end else if (!flush && pk_a_vld) begin
            ptr_d = oh2idx(pk_a) + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end
`endif

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ent
            logic      vld_q, vld_d;
            wk_entry_t dat_q, dat_d;

            always_comb begin
                vld_d = vld_q;
                dat_d = dat_q;
                if (flush) begin
                    vld_d = 1'b0;
                end else if (xfer[gi]) begin
                    // a granted entry may be refilled in the same cycle
                    vld_d = 1'b1;
                    dat_d.rob   = req_rob[gi*ROB_W +: ROB_W];
                    dat_d.value = req_value[gi*VAL_W +: VAL_W];
                end else if (grant[gi]) begin
                    vld_d = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (!resetn) begin
                    vld_q <= 1'b0;
                    dat_q <= '0;
                end else begin
                    vld_q <= vld_d;
                    dat_q <= dat_d;
                end
            end

            assign ent_vld[gi] = vld_q;
            assign ent[gi]     = dat_q;
        end
    endgenerate

    logic      wea_q, wea_d, web_q, web_d;
    wk_entry_t pa_q, pa_d, pb_q, pb_d;

    always_comb begin
        wea_d = pk_a_vld & ~flush;
        web_d = pk_b_vld & ~flush;
        pa_d  = pa_q;
        pb_d  = pb_q;
        if (wea_d) pa_d = ent[oh2idx(pk_a)];
        if (web_d) pb_d = ent[oh2idx(pk_b)];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wea_q <= 1'b0;
            web_q <= 1'b0;
            pa_q  <= '0;
            pb_q  <= '0;
        end else begin
            wea_q <= wea_d;
            web_q <= web_d;
            pa_q  <= pa_d;
            pb_q  <= pb_d;
        end
    end

    assign wea        = wea_q;
    assign dina_rob   = pa_q.rob;
    assign dina_value = pa_q.value;
    assign web        = web_q;
    assign dinb_rob   = pb_q.rob;
    assign dinb_value = pb_q.value;
endmodule

// File: tb/tb_issue_wakeup_arb.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_issue_wakeup_arb;
    logic         clk = 1'b0;
    logic         resetn, flush;
    logic [3:0]   req_valid;
    logic [15:0]  req_rob;
    logic [127:0] req_value;
    logic [3:0]   req_ready;
    logic         wea, web;
    logic [3:0]   dina_rob, dinb_rob;
    logic [31:0]  dina_value, dinb_value;

    always #5 clk = ~clk;

    issue_wakeup_arb dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_rob    (req_rob),
        .req_value  (req_value),
        .req_ready  (req_ready),
        .wea        (wea),
        .dina_rob   (dina_rob),
        .dina_value (dina_value),
        .web        (web),
        .dinb_rob   (dinb_rob),
        .dinb_value (dinb_value)
    );

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    bit          mv   [4] = '{0, 0, 0, 0};
    logic [3:0]  mrob [4] = '{0, 0, 0, 0};
    logic [31:0] mval [4] = '{0, 0, 0, 0};
    int          mptr = 0;
    bit          mwea = 0, mweb = 0;
    logic [3:0]  marob = 0, mbrob = 0;
    logic [31:0] maval = 0, mbval = 0;
    int          mg [2];
    int          mgn;
    logic [3:0]  mready;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_granted(input int i);
        return (mgn > 0 && mg[0] == i) || (mgn > 1 && mg[1] == i);
    endfunction

    // Grants and ready for the current cycle from the model's entries and pointer
    function automatic void model_comb();
        int start;
`ifdef ISSUE_WAKEUP_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = mptr;
`endif
        mgn = 0;
        mg[0] = 0;
        mg[1] = 0;
        if (!flush) begin
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (start + k) % 4;
                if (mv[i] && mgn < 2) begin
                    mg[mgn] = i;
                    mgn++;
                end
            end
        end
        for (int i = 0; i < 4; i++)
            mready[i] = flush ? 1'b0 : (!mv[i] || is_granted(i));
    endfunction

    task automatic compare();
        model_comb();
        chk("req_ready",  {28'b0, req_ready}, {28'b0, mready});
        chk("wea",        {31'b0, wea},       {31'b0, mwea});
        chk("web",        {31'b0, web},       {31'b0, mweb});
        chk("dina_rob",   {28'b0, dina_rob},  {28'b0, marob});
        chk("dina_value", dina_value,         maval);
        chk("dinb_rob",   {28'b0, dinb_rob},  {28'b0, mbrob});
        chk("dinb_value", dinb_value,         mbval);
    endtask

    task automatic model_update();
        if (!resetn) begin
            for (int i = 0; i < 4; i++) begin
                mv[i] = 0; mrob[i] = 0; mval[i] = 0;
            end
            mptr = 0; mwea = 0; mweb = 0;
            marob = 0; mbrob = 0; maval = 0; mbval = 0;
        end else begin
            model_comb();
            mwea = (mgn >= 1);
            mweb = (mgn >= 2);
            if (mwea) begin marob = mrob[mg[0]]; maval = mval[mg[0]]; end
            if (mweb) begin mbrob = mrob[mg[1]]; mbval = mval[mg[1]]; end
            for (int i = 0; i < 4; i++) begin
                if (flush) mv[i] = 0;
                else if (req_valid[i] && mready[i]) begin
                    mv[i] = 1;
                    mrob[i] = req_rob[4*i +: 4];
                    mval[i] = req_value[32*i +: 32];
                end else if (is_granted(i)) mv[i] = 0;
            end
            if (mgn > 0) mptr = (mg[mgn-1] + 1) % 4;
        end
    endtask

    task automatic step();
        #1;
        compare();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        flush = 1'b0;
        req_valid = '0;
        step();
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0;
        flush = 1'b0;
        req_valid = '0;
        req_rob = '0;
        req_value = '0;
        @(posedge clk);
        #1;
        step();

        // Single wake-up, two-cycle latency
        do_reset();
        chk("ready_after_reset", {28'b0, req_ready}, 32'hF);
        req_valid = 4'b0001; req_rob = 16'h0003; req_value[31:0] = 32'hDEAD_BEEF;
        step();
        req_valid = '0;
        step();
        chk("single_wea", {31'b0, wea}, 32'd1);
        chk("single_rob", {28'b0, dina_rob}, 32'd3);
        chk("single_val", dina_value, 32'hDEAD_BEEF);
        chk("single_web", {31'b0, web}, 32'd0);
        step();

        // All four valid continuously from pointer 0
        do_reset();
        req_valid = 4'hF; req_rob = 16'h3210;
        req_value = {32'd3, 32'd2, 32'd1, 32'd0};
        step(); step();
`ifdef ISSUE_WAKEUP_ARB_FIXED_PRIO_EN
        for (int c = 0; c < 3; c++) begin
            chk("fp_a", {28'b0, dina_rob}, 32'd0);
            chk("fp_b", {28'b0, dinb_rob}, 32'd1);
            chk("fp_ready_hi", {30'b0, req_ready[3:2]}, 32'd0);
            step();
        end
`else
        chk("rr1_a", {28'b0, dina_rob}, 32'd0);
        chk("rr1_b", {28'b0, dinb_rob}, 32'd1);
        step();
        chk("rr2_a", {28'b0, dina_rob}, 32'd2);
        chk("rr2_b", {28'b0, dinb_rob}, 32'd3);
        step();
        chk("rr3_a", {28'b0, dina_rob}, 32'd0);
        chk("rr3_b", {28'b0, dinb_rob}, 32'd1);
        chk("rr3_web", {31'b0, web}, 32'd1);
        step();
`endif

        // Requester 2 streaming alone: reload every cycle
        do_reset();
        req_valid = 4'b0100; req_rob = 16'h0900;
        for (int k = 0; k < 6; k++) begin
            req_value[95:64] = $urandom;
            chk("stream_ready2", {31'b0, req_ready[2]}, 32'd1);
            if (k >= 2) begin
                chk("stream_wea", {31'b0, wea}, 32'd1);
                chk("stream_rob", {28'b0, dina_rob}, 32'd9);
            end
            step();
        end

        // Flush discards loaded entries
        do_reset();
        req_valid = 4'hF; req_rob = 16'h7654;
        req_value = {32'hF03, 32'hF02, 32'hF01, 32'hF00};
        step();
        req_valid = '0; flush = 1'b1;
        #1;
        chk("flush_ready", {28'b0, req_ready}, 32'd0);
        step();
        flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("flush_wea", {31'b0, wea}, 32'd0);
            chk("flush_web", {31'b0, web}, 32'd0);
            step();
        end

        // Reset mid-operation with entries 1 and 3 valid
        do_reset();
        req_valid = 4'b1010; req_rob = 16'hB0A0;
        req_value = {32'h3333_3333, 32'h0, 32'h1111_1111, 32'h0};
        step();
        req_valid = '0; resetn = 1'b0;
        step();
        resetn = 1'b1;
        #1;
        chk("rst_ready", {28'b0, req_ready}, 32'hF);
        chk("rst_dina_rob", {28'b0, dina_rob}, 32'd0);
        chk("rst_dina_val", dina_value, 32'd0);
        chk("rst_dinb_rob", {28'b0, dinb_rob}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            chk("rst_wea", {31'b0, wea}, 32'd0);
            chk("rst_web", {31'b0, web}, 32'd0);
            step();
        end

        // Randomized traffic with occasional flush and reset
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            resetn = ($urandom_range(0, 99) != 0);
            flush = ($urandom_range(0, 19) == 0);
            req_valid = 4'($urandom);
            req_rob = 16'($urandom);
            req_value = {$urandom, $urandom, $urandom, $urandom};
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/issue_wakeup_arb.md
ISSUE_WAKEUP_ARB -- requirements
Module: issue_wakeup_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of wake-up requesters (fixed at 4 in this revision).
REQ-002 SHALL have clk  input  1  sole clock, rising edge.
REQ-003 SHALL have resetn  input  1  synchronous active-low reset.
REQ-004 SHALL have flush  input  1  pipeline flush; discards buffered and in-flight wake-ups.
REQ-005 SHALL have req_valid  input  NREQ  per-requester wake-up valid.
REQ-006 SHALL have req_rob  input  NREQ*4  per-requester ROB tag, requester i at bits [4i+3:4i].
REQ-007 SHALL have req_value  input  NREQ*32  per-requester result, requester i at bits [32i+31:32i].
REQ-008 SHALL have req_ready  output  NREQ  per-requester accept; transfer when valid and ready both high.
REQ-009 SHALL have wea / dina_rob / dina_value  output  1/4/32  wake-up port A toward the history table.
REQ-010 SHALL have web / dinb_rob / dinb_value  output  1/4/32  wake-up port B toward the history table.

Function
REQ-011 SHALL hold one skid entry (valid, rob, value) per requester; entry loads on transfer.
REQ-012 SHALL drive req_ready[i] = ~entry_valid[i] | grant[i]; req_ready SHALL NOT depend on req_valid.
REQ-013 SHALL grant up to two valid entries per cycle, scanning from the round-robin pointer upward modulo NREQ.
REQ-014 SHALL route the first grant in scan order to port A and the second to port B; a single grant SHALL use port A only.
REQ-015 SHALL register outputs: entry granted in cycle N appears on wea/web in cycle N+1; input-to-output latency is 2 cycles minimum.
REQ-016 SHALL clear a granted entry, and SHALL reload it in the same cycle if its requester transfers then.
REQ-017 SHALL advance the pointer to (last granted index + 1) mod NREQ; no grant leaves the pointer unchanged.
REQ-018 SHALL deassert wea/web in any cycle following a cycle with no corresponding grant; dina/dinb data then hold previous values.
REQ-019 On flush, SHALL clear all entries, issue no grant, force wea=web=0 next cycle, drive req_ready=0 that cycle, and keep the pointer.
REQ-020 SHALL NOT check for duplicate ROB tags; uniqueness of outstanding tags is the requesters' responsibility.

Reset
REQ-021 While resetn=0 at a clock edge: all entries invalid, pointer=0, wea=web=0, dina/dinb rob and value=0.
REQ-022 req_ready SHALL read all-ones the cycle after reset release.
REQ-023 Reset mid-operation SHALL discard all buffered wake-ups without emitting them.

Configuration
REQ-024 Macro ISSUE_WAKEUP_ARB_FIXED_PRIO_EN, when defined, SHALL replace round-robin with fixed priority (requester 0 highest, scan always from 0) and remove the pointer register.
REQ-025 Without ISSUE_WAKEUP_ARB_FIXED_PRIO_EN, round-robin per REQ-013/REQ-017 SHALL apply.

Structure
REQ-026 ROB tag width (4), value width (32) and NREQ default SHALL come from the shared issue-stage package/header, shared with the wake-up history table.
REQ-027 Two-of-N selection SHALL be a sub-module issue_wakeup_pick2: inputs mask and start index, outputs two one-hot grants with valid bits; combinational only.

Verification
REQ-028 Reset, then req_valid=4'b0001, rob=3, value=32'hDEAD_BEEF one cycle -> wea=1, dina_rob=3, dina_value=32'hDEADBEEF two cycles later; web=0.
REQ-029 All four requesters valid every cycle from reset (pointer 0) -> grants {0,1},{2,3},{0,1} cycles 1..3; port A gets 0,2,0, port B gets 1,3,1.
REQ-030 Requester 2 held valid continuously with others idle -> one wake-up per cycle on port A, req_ready[2] constantly 1 (same-cycle reload).
REQ-031 Entries 0..3 loaded, flush asserted next cycle -> wea=web=0 the following cycle, req_ready=0 during flush, none of the four tags ever emitted.
REQ-032 ISSUE_WAKEUP_ARB_FIXED_PRIO_EN defined, all requesters valid continuously -> only requesters 0 and 1 ever granted; req_ready[3:2]=0 once loaded.
REQ-033 resetn=0 asserted while entries 1 and 3 valid -> no wake-up emitted afterward; outputs zero; req_ready=4'b1111 after release.
